// File: rtl/systolic_pe_if.sv
// systolic_pe_if -- operand/result bundle of one systolic processing element.
//
// Signals (directions as seen from the PE, i.e. the slave modport):
//   a_in_valid/a_in_last/a_in_data  in   west operand stream
//   a_in_ready                      out  west operand accepted
//   b_in_valid/b_in_last/b_in_data  in   north operand stream
//   b_in_ready                      out  north operand accepted
//   a_out_valid/a_out_last/a_out_data out east forwarded operand
//   a_out_ready                     in   east neighbour ready
//   b_out_valid/b_out_last/b_out_data out south forwarded operand
//   b_out_ready                     in   south neighbour ready
//   c_out_valid/c_out_data/c_out_count out dot-product result and product count
//   c_out_ready                     in   result consumer ready
//   err_last                        out  sticky a/b last mismatch
//   sat_flag                        out  saturation occurred in current result
// The master modport is the environment side (neighbours / test driver).
interface systolic_pe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64,
    parameter int CNT_WIDTH  = 16
);
    logic                  a_in_valid;
    logic                  a_in_last;
    logic [DATA_WIDTH-1:0] a_in_data;
    logic                  a_in_ready;
    logic                  b_in_valid;
    logic                  b_in_last;
    logic [DATA_WIDTH-1:0] b_in_data;
    logic                  b_in_ready;
    logic                  a_out_valid;
    logic                  a_out_last;
    logic [DATA_WIDTH-1:0] a_out_data;
    logic                  a_out_ready;
    logic                  b_out_valid;
    logic                  b_out_last;
    logic [DATA_WIDTH-1:0] b_out_data;
    logic                  b_out_ready;
    logic                  c_out_valid;
    logic [ACC_WIDTH-1:0]  c_out_data;
    logic [CNT_WIDTH-1:0]  c_out_count;
    logic                  c_out_ready;
    logic                  err_last;
    logic                  sat_flag;

    modport slave (
        input  a_in_valid, a_in_last, a_in_data,
        output a_in_ready,
        input  b_in_valid, b_in_last, b_in_data,
        output b_in_ready,
        output a_out_valid, a_out_last, a_out_data,
        input  a_out_ready,
        output b_out_valid, b_out_last, b_out_data,
        input  b_out_ready,
        output c_out_valid, c_out_data, c_out_count,
        input  c_out_ready,
        output err_last, sat_flag
    );

    modport master (
        output a_in_valid, a_in_last, a_in_data,
        input  a_in_ready,
        output b_in_valid, b_in_last, b_in_data,
        input  b_in_ready,
        input  a_out_valid, a_out_last, a_out_data,
        output a_out_ready,
        input  b_out_valid, b_out_last, b_out_data,
        output b_out_ready,
        input  c_out_valid, c_out_data, c_out_count,
        output c_out_ready,
        input  err_last, sat_flag
    );
endinterface

// File: rtl/systolic_pe.sv
// systolic_pe -- multiply-accumulate processing element for a systolic array.
// West (a) and north (b) operands are consumed together, multiplied and added
// into an accumulator, and forwarded east/south through one-deep registers.
// A fire carrying "last" emits the dot product with its product count.
//
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  synchronous active-low reset
//   pe     systolic_pe_if.slave -- operand, forward and result handshakes
//
// Parameters: DATA_WIDTH (operand), ACC_WIDTH (>= 2*DATA_WIDTH, result),
//   CNT_WIDTH (product counter), SIGNED (1 = two's complement, 0 = unsigned).
//   The interface instance must use the same DATA/ACC/CNT widths.
//
// Build option: define SYSTOLIC_PE_SAT_EN to clamp the accumulator at the
// representable ACC_WIDTH range and report it on sat_flag; otherwise the sum
// wraps and sat_flag is tied low.
module systolic_pe #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int SIGNED     = 1
) (
    input logic          clk,
    input logic          rst_n,
    systolic_pe_if.slave pe
);
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

    state_t                state_q;
    logic [ACC_WIDTH-1:0]  acc_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;
    logic                  a_fwd_valid_q;
    logic                  a_fwd_last_q;
    logic [DATA_WIDTH-1:0] a_fwd_data_q;
    logic                  b_fwd_valid_q;
    logic                  b_fwd_last_q;
    logic [DATA_WIDTH-1:0] b_fwd_data_q;
    logic                  c_valid_q;
    logic [ACC_WIDTH-1:0]  c_data_q;
    logic [CNT_WIDTH-1:0]  c_count_q;
    logic                  err_q;

    logic                  in_ready;
    logic                  fire;
    logic                  is_last;
    logic                  c_hs;
    logic [ACC_WIDTH-1:0]  prod_ext;
    logic [ACC_WIDTH-1:0]  sum_next;

    always_comb begin
        in_ready = (state_q == RUN)
                 && (!a_fwd_valid_q || pe.a_out_ready)
                 && (!b_fwd_valid_q || pe.b_out_ready);
        fire     = pe.a_in_valid && pe.b_in_valid && in_ready;
        // a one-sided last still closes the vector
        is_last  = pe.a_in_last || pe.b_in_last;
        c_hs     = (state_q == OUT) && pe.c_out_ready;
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    end

    // Full-width product, then sign- or zero-extension to the accumulator.
    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [PW-1:0] prod_s;
            assign prod_s   = PW'($signed(pe.a_in_data)) * PW'($signed(pe.b_in_data));
            assign prod_ext = ACC_WIDTH'(prod_s);
        end else begin : g_unsigned
            logic [PW-1:0] prod_u;
            assign prod_u   = PW'(pe.a_in_data) * PW'(pe.b_in_data);
            assign prod_ext = ACC_WIDTH'(prod_u);
        end
    endgenerate

`ifdef SYSTOLIC_PE_SAT_EN
    localparam logic [ACC_WIDTH-1:0] S_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] S_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH-1:0] sum_raw;
    logic                 ovf;
    logic                 sat_q;

    always_comb begin
        sum_wide = {1'b0, acc_q} + {1'b0, prod_ext};
        sum_raw  = sum_wide[ACC_WIDTH-1:0];
        if (SIGNED != 0) begin
            // signed overflow: same-sign operands produce a different-sign sum
            ovf      = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1])
                    && (sum_raw[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
            sum_next = ovf ? (acc_q[ACC_WIDTH-1] ? S_MIN : S_MAX) : sum_raw;
        end else begin
            ovf      = sum_wide[ACC_WIDTH];
            sum_next = ovf ? '1 : sum_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (c_hs) begin
            sat_q <= 1'b0;
        end else if (fire && ovf) begin
            sat_q <= 1'b1;
        end
    end

    assign pe.sat_flag = sat_q;
`else
    always_comb begin
        sum_next = acc_q + prod_ext;
    end

    assign pe.sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            cnt_q         <= '0;
            a_fwd_valid_q <= 1'b0;
            a_fwd_last_q  <= 1'b0;
            a_fwd_data_q  <= '0;
            b_fwd_valid_q <= 1'b0;
            b_fwd_last_q  <= 1'b0;
            b_fwd_data_q  <= '0;
            c_valid_q     <= 1'b0;
            c_data_q      <= '0;
            c_count_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            // Forward slots drain in every state; a fire is only possible
            // when both slots are free, so loading never overwrites data.
            if (fire) begin
                a_fwd_valid_q <= 1'b1;
                a_fwd_last_q  <= pe.a_in_last;
                a_fwd_data_q  <= pe.a_in_data;
                b_fwd_valid_q <= 1'b1;
                b_fwd_last_q  <= pe.b_in_last;
                b_fwd_data_q  <= pe.b_in_data;
            end else begin
                if (pe.a_out_ready) a_fwd_valid_q <= 1'b0;
                if (pe.b_out_ready) b_fwd_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    if (fire) begin
                        acc_q <= sum_next;
                        cnt_q <= cnt_d;
                        if (pe.a_in_last != pe.b_in_last) err_q <= 1'b1;
                        if (is_last) begin
                            c_valid_q <= 1'b1;
                            c_data_q  <= sum_next;
                            c_count_q <= cnt_d;
                            state_q   <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (pe.c_out_ready) begin
                        c_valid_q <= 1'b0;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= RUN;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pe.a_in_ready  = in_ready;
    assign pe.b_in_ready  = in_ready;
    assign pe.a_out_valid = a_fwd_valid_q;
    assign pe.a_out_last  = a_fwd_last_q;
    assign pe.a_out_data  = a_fwd_data_q;
    assign pe.b_out_valid = b_fwd_valid_q;
    assign pe.b_out_last  = b_fwd_last_q;
    assign pe.b_out_data  = b_fwd_data_q;
    assign pe.c_out_valid = c_valid_q;
    assign pe.c_out_data  = c_data_q;
    assign pe.c_out_count = c_count_q;
    assign pe.err_last    = err_q;
endmodule

// File: tb/tb_systolic_pe.sv
`timescale 1ns/1ps
module tb_systolic_pe;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    systolic_pe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) ifs ();
    systolic_pe_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) ifu ();

    systolic_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .SIGNED(1)) u_pe_s (
        .clk(clk), .rst_n(rst_n), .pe(ifs.slave)
    );
    systolic_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .SIGNED(0)) u_pe_u (
        .clk(clk), .rst_n(rst_n), .pe(ifu.slave)
    );

    assign ifu.a_out_ready = 1'b1;
    assign ifu.b_out_ready = 1'b1;
    assign ifu.c_out_ready = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // 0 = low, 1 = high, 2 = random per cycle
    int a_rdy_mode = 1;
    int b_rdy_mode = 1;
    int c_rdy_mode = 1;

    function automatic logic pick(input int m);
        if (m == 2) return 1'($urandom_range(0, 1));
        return (m == 1);
    endfunction

    initial begin
        ifs.a_out_ready = 1'b1;
        ifs.b_out_ready = 1'b1;
        ifs.c_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            ifs.a_out_ready = pick(a_rdy_mode);
            ifs.b_out_ready = pick(b_rdy_mode);
            ifs.c_out_ready = pick(c_rdy_mode);
        end
    end

    // Reference model for the signed PE: forwarded operand queues and a
    // per-vector integer dot product, wrapped or clamped to 16 bits.
    int              q_a[$];
    int              q_b[$];
    logic [AW-1:0]   q_res[$];
    int              q_cnt[$];
    logic            q_sat[$];
    logic            q_err[$];
    longint          m_sum = 0;
    int              m_n   = 0;
    logic            m_sat = 1'b0;
    logic            m_err = 1'b0;
    int              fa, fb;

    always @(negedge clk) begin
        if (!rst_n) begin
            q_a.delete(); q_b.delete(); q_res.delete(); q_cnt.delete();
            q_sat.delete(); q_err.delete();
            m_sum = 0; m_n = 0; m_sat = 1'b0; m_err = 1'b0;
        end else begin
            check("ready_equal", 32'(ifs.a_in_ready), 32'(ifs.b_in_ready));
            if ((ifs.a_out_valid && !ifs.a_out_ready) || (ifs.b_out_valid && !ifs.b_out_ready)
                || ifs.c_out_valid)
                check("ready_blocked", 32'(ifs.a_in_ready), 32'd0);
            if (ifs.a_out_valid && ifs.a_out_ready) begin
                if (q_a.size() == 0) check("a_fwd_extra", 32'd1, 32'd0);
                else check("a_fwd", 32'({ifs.a_out_last, ifs.a_out_data}), 32'(q_a.pop_front()));
            end
            if (ifs.b_out_valid && ifs.b_out_ready) begin
                if (q_b.size() == 0) check("b_fwd_extra", 32'd1, 32'd0);
                else check("b_fwd", 32'({ifs.b_out_last, ifs.b_out_data}), 32'(q_b.pop_front()));
            end
            if (ifs.c_out_valid && ifs.c_out_ready) begin
                if (q_res.size() == 0) check("c_extra", 32'd1, 32'd0);
                else begin
                    check("c_data",  32'(ifs.c_out_data),  32'(q_res.pop_front()));
                    check("c_count", 32'(ifs.c_out_count), 32'(q_cnt.pop_front()));
                    check("c_sat",   32'(ifs.sat_flag),    32'(q_sat.pop_front()));
                    check("c_err",   32'(ifs.err_last),    32'(q_err.pop_front()));
                end
            end
            if (ifs.a_in_valid && ifs.b_in_valid && ifs.a_in_ready) begin
                q_a.push_back(int'({ifs.a_in_last, ifs.a_in_data}));
                q_b.push_back(int'({ifs.b_in_last, ifs.b_in_data}));
                fa = int'($signed(ifs.a_in_data));
                fb = int'($signed(ifs.b_in_data));
                m_sum += longint'(fa * fb);
`ifdef SYSTOLIC_PE_SAT_EN
                if (m_sum > 32767) begin m_sum = 32767; m_sat = 1'b1; end
                else if (m_sum < -32768) begin m_sum = -32768; m_sat = 1'b1; end
`endif
                m_n++;
                if (ifs.a_in_last != ifs.b_in_last) m_err = 1'b1;
                if (ifs.a_in_last || ifs.b_in_last) begin
                    q_res.push_back(AW'(m_sum));
                    q_cnt.push_back((m_n > 15) ? 15 : m_n);
                    q_sat.push_back(m_sat);
                    q_err.push_back(m_err);
                    m_sum = 0; m_n = 0; m_sat = 1'b0;
                end
            end
        end
    end

    task automatic send(input bit uns, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic al, input logic bl);
        bit done = 1'b0;
        if (uns) begin
            ifu.a_in_data = a; ifu.b_in_data = b; ifu.a_in_last = al; ifu.b_in_last = bl;
            ifu.a_in_valid = 1'b1; ifu.b_in_valid = 1'b1;
        end else begin
            ifs.a_in_data = a; ifs.b_in_data = b; ifs.a_in_last = al; ifs.b_in_last = bl;
            ifs.a_in_valid = 1'b1; ifs.b_in_valid = 1'b1;
        end
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = uns ? ifu.a_in_ready : ifs.a_in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        if (uns) begin ifu.a_in_valid = 1'b0; ifu.b_in_valid = 1'b0; end
        else     begin ifs.a_in_valid = 1'b0; ifs.b_in_valid = 1'b0; end
    endtask

    task automatic wait_c_done();
        for (int t = 0; t < 300 && ifs.c_out_valid; t++) begin
            @(posedge clk);
            #1;
        end
        check("c_drain", 32'(ifs.c_out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    longint tot;
    logic [AW-1:0] exp_u;
    logic          exp_us;
    int            len;

    initial begin
        ifs.a_in_valid = 1'b0; ifs.b_in_valid = 1'b0; ifs.a_in_last = 1'b0; ifs.b_in_last = 1'b0;
        ifs.a_in_data = '0; ifs.b_in_data = '0;
        ifu.a_in_valid = 1'b0; ifu.b_in_valid = 1'b0; ifu.a_in_last = 1'b0; ifu.b_in_last = 1'b0;
        ifu.a_in_data = '0; ifu.b_in_data = '0;
        rst_n = 1'b0;
        repeat (3) begin @(posedge clk); #1; end

        // reset state
        check("rst_ctrl", 32'({ifs.a_in_ready, ifs.b_in_ready, ifs.a_out_valid, ifs.b_out_valid,
                               ifs.c_out_valid, ifs.err_last, ifs.sat_flag}), 32'd0);
        check("rst_data", 32'({ifs.c_out_data, ifs.c_out_count, ifs.a_out_data}), 32'd0);
        check("rst_u_ctrl", 32'({ifu.a_in_ready, ifu.c_out_valid, ifu.sat_flag, ifu.err_last}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(ifs.a_in_ready), 32'd0);
        @(posedge clk); #1;
        check("run_ready", 32'(ifs.a_in_ready), 32'd1);

        // (3,4),(-2,5),(7,-1) -> -5
        send(0, 8'd3, 8'd4, 1'b0, 1'b0);
        send(0, 8'hFE, 8'd5, 1'b0, 1'b0);
        send(0, 8'd7, 8'hFF, 1'b1, 1'b1);
        check("dot3_valid", 32'(ifs.c_out_valid), 32'd1);
        check("dot3_data",  32'(ifs.c_out_data), 32'h0000FFFB);
        check("dot3_count", 32'(ifs.c_out_count), 32'd3);
        @(posedge clk); #1;
        check("dot3_clear", 32'(ifs.c_out_valid), 32'd0);

        // east back-pressure stalls inputs and holds the forwarded operand
        a_rdy_mode = 0;
        send(0, 8'd10, 8'd20, 1'b0, 1'b0);
        ifs.a_in_valid = 1'b1; ifs.b_in_valid = 1'b1;
        ifs.a_in_data = 8'd30; ifs.b_in_data = 8'd40;
        repeat (3) begin
            @(negedge clk);
            check("stall_ready", 32'(ifs.a_in_ready), 32'd0);
            check("stall_data",  32'({ifs.a_out_valid, ifs.a_out_data}), 32'h10A);
        end
        @(posedge clk); #1;
        a_rdy_mode = 1;
        send(0, 8'd30, 8'd40, 1'b0, 1'b0);
        send(0, 8'd50, 8'd60, 1'b1, 1'b1);
        check("stall_sum", 32'(ifs.c_out_data), 32'd4400);
        wait_c_done();

        // result held while the consumer is not ready
        c_rdy_mode = 0;
        send(0, 8'd5, 8'd6, 1'b0, 1'b0);
        send(0, 8'hFD, 8'd4, 1'b1, 1'b1);
        ifs.a_in_valid = 1'b1; ifs.b_in_valid = 1'b1;
        ifs.a_in_data = 8'd1; ifs.b_in_data = 8'd1;
        repeat (4) begin
            @(negedge clk);
            check("hold_out", 32'({ifs.c_out_valid, ifs.c_out_count, ifs.c_out_data}), 32'h1_2_0012);
            check("hold_noacc", 32'(ifs.a_in_ready), 32'd0);
        end
        ifs.a_in_valid = 1'b0; ifs.b_in_valid = 1'b0;
        c_rdy_mode = 1;
        wait_c_done();
        send(0, 8'd1, 8'd1, 1'b1, 1'b1);
        check("acc_cleared", 32'({ifs.c_out_count, ifs.c_out_data}), 32'h1_0001);
        wait_c_done();

        // a/b last mismatch then reset mid-vector
        send(0, 8'd2, 8'd3, 1'b1, 1'b0);
        check("err_result", 32'({ifs.c_out_valid, ifs.c_out_data}), 32'h1_0006);
        check("err_set", 32'(ifs.err_last), 32'd1);
        wait_c_done();
        send(0, 8'd1, 8'd2, 1'b0, 1'b0);
        send(0, 8'd1, 8'd1, 1'b1, 1'b1);
        check("err_sticky", 32'(ifs.err_last), 32'd1);
        wait_c_done();
        a_rdy_mode = 0;
        send(0, 8'd4, 8'd4, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ctrl", 32'({ifs.a_in_ready, ifs.a_out_valid, ifs.b_out_valid,
                                  ifs.c_out_valid, ifs.err_last, ifs.sat_flag}), 32'd0);
        check("midrst_data", 32'({ifs.c_out_data, ifs.a_out_data}), 32'd0);
        a_rdy_mode = 1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, 8'd2, 8'd5, 1'b1, 1'b1);
        check("after_rst", 32'({ifs.c_out_count, ifs.c_out_data}), 32'h1_000A);
        wait_c_done();

        // unsigned 3 x (255,255) into a 16-bit accumulator
        tot = 3 * 255 * 255;
`ifdef SYSTOLIC_PE_SAT_EN
        exp_u  = (tot > 65535) ? 16'hFFFF : AW'(tot);
        exp_us = (tot > 65535);
`else
        exp_u  = AW'(tot % 65536);
        exp_us = 1'b0;
`endif
        send(1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        send(1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        send(1, 8'hFF, 8'hFF, 1'b1, 1'b1);
        check("uns_valid", 32'(ifu.c_out_valid), 32'd1);
        check("uns_data",  32'(ifu.c_out_data), 32'(exp_u));
        check("uns_sat",   32'(ifu.sat_flag), 32'(exp_us));
        check("uns_count", 32'(ifu.c_out_count), 32'd3);

        // randomized vectors with random back-pressure on all sides
        a_rdy_mode = 2; b_rdy_mode = 2; c_rdy_mode = 2;
        for (int v = 0; v < 30; v++) begin
            len = (v == 0) ? 18 : $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                send(0, 8'($urandom), 8'($urandom), (k == len - 1), (k == len - 1));
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        end
        a_rdy_mode = 1; b_rdy_mode = 1; c_rdy_mode = 1;
        for (int t = 0; t < 500 && (q_res.size() + q_a.size() + q_b.size()) != 0; t++) begin
            @(posedge clk); #1;
        end
        check("final_drain", 32'(q_res.size() + q_a.size() + q_b.size()), 32'd0);

        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
